// File: rtl/bounce_shifter_if.sv
// Signal bundle for the bounce_shifter LED sweep engine.
//
// Carries the control inputs (en, mode, div, load, load_val) and the
// registered status outputs (Q, dir, step, bounce). clk and reset are
// kept as plain module ports.
//   master : drives the controls and observes the status (board logic / bench)
//   slave  : the sweep engine itself
interface bounce_shifter_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic             dir;
    logic             step;
    logic             bounce;

    modport master (
        output en, mode, div, load, load_val,
        input  Q, dir, step, bounce
    );

    modport slave (
        input  en, mode, div, load, load_val,
        output Q, dir, step, bounce
    );
endinterface

// File: rtl/bounce_shifter.sv
// bounce_shifter: parametrised LED sweep engine.
//
// A WIDTH-bit pattern walks between the two ends of Q and reverses at each
// end (ping-pong), or rotates left/right, or holds. A prescaler advances the
// pattern once every div+1 enabled cycles. All outputs are registered.
//
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous, active-high reset
//   bus    : bounce_shifter_if.slave
//            en       step enable (0 freezes prescaler and pattern)
//            mode     00 bounce, 01 rotate left, 10 rotate right, 11 hold
//            div      step every div+1 enabled cycles
//            load     load load_val into Q this cycle (clears prescaler)
//            Q        current pattern
//            dir      0 = moving toward MSB, 1 = moving toward LSB
//            step     pulse in the cycle Q shows a newly advanced value
//            bounce   pulse in the cycle after a direction reversal
module bounce_shifter #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    bounce_shifter_if.slave    bus
);

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROTL   = 2'b01;
    localparam logic [1:0] MODE_ROTR   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [WIDTH-1:0] q_q,      q_d;
    logic             dir_q,    dir_d;
    logic [DIV_W-1:0] cnt_q,    cnt_d;
    logic             step_q,   step_d;
    logic             bounce_q, bounce_d;

    // End of the bank the pattern is heading toward, and the end it is
    // leaving. Both set (e.g. 1000_0001) means a shift either way would drop
    // a lit bit, so only the direction flips.
    logic lead_end;
    logic trail_end;

    always_comb begin
        q_d       = q_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        bounce_d  = 1'b0;
        lead_end  = dir_q ? q_q[0] : q_q[WIDTH-1];
        trail_end = dir_q ? q_q[WIDTH-1] : q_q[0];

        if (bus.load) begin
            q_d   = bus.load_val;
            cnt_d = '0;
        end else if (bus.en && (bus.mode != MODE_HOLD)) begin
            // Compare against the live div so lowering it mid-count steps at once.
            if (cnt_q >= bus.div) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (bus.mode)
                    MODE_BOUNCE: begin
                        // An all-zero pattern has no ends to bounce off.
                        if (q_q != '0) begin
                            if (!lead_end) begin
                                q_d = dir_q ? (q_q >> 1) : (q_q << 1);
                            end else begin
                                dir_d    = ~dir_q;
                                bounce_d = 1'b1;
                                if (!trail_end) begin
                                    q_d = dir_q ? (q_q << 1) : (q_q >> 1);
                                end
                            end
                        end
                    end
                    MODE_ROTL: begin
                        q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        dir_d = 1'b0;
                    end
                    MODE_ROTR: begin
                        q_d   = {q_q[0], q_q[WIDTH-1:1]};
                        dir_d = 1'b1;
                    end
                    default: begin
                        q_d = q_q;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= WIDTH'(1);
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            step_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            bounce_q <= bounce_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.dir    = dir_q;
    assign bus.step   = step_q;
    assign bus.bounce = bounce_q;

endmodule

// File: tb/tb_bounce_shifter.sv
// Directed bench for bounce_shifter (WIDTH=8, DIV_W=4).
// Inputs change #1 after a rising edge; outputs are sampled at that point,
// i.e. the values registered by the edge just passed.
module tb_bounce_shifter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    bounce_shifter_if #(.WIDTH(8), .DIV_W(4)) bus ();

    bounce_shifter #(.WIDTH(8), .DIV_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.en       = 1'b0;
        tick();
        reset        = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.mode = 2'b00; bus.div = 4'd0;
        tick();
        do_reset();
        $display("reset: Q=%h dir=%b step=%b bounce=%b", bus.Q, bus.dir, bus.step, bus.bounce);
        n_cmp++; if (bus.Q !== 8'h01) begin n_err++; $display("FAIL reset_q got %h want 01", bus.Q); end
        n_cmp++; if (bus.dir !== 1'b0) begin n_err++; $display("FAIL reset_dir got %b want 0", bus.dir); end
        n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL reset_step got %b want 0", bus.step); end
        n_cmp++; if (bus.bounce !== 1'b0) begin n_err++; $display("FAIL reset_bounce got %b want 0", bus.bounce); end
    endtask

    task automatic test_bounce_sweep();
        logic [7:0] exp_q [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        logic       exp_d [15] = '{0,0,0,0,0,0,0, 1,1,1,1,1,1,1, 0};
        logic       exp_b [15] = '{0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 1};
        do_reset();
        bus.en = 1'b1; bus.mode = 2'b00; bus.div = 4'd0;
        for (int i = 0; i < 15; i++) begin
            tick();
            $display("sweep %0d: Q=%h dir=%b step=%b bounce=%b", i, bus.Q, bus.dir, bus.step, bus.bounce);
            n_cmp++; if (bus.Q !== exp_q[i]) begin n_err++; $display("FAIL sweep_q[%0d] got %h want %h", i, bus.Q, exp_q[i]); end
            n_cmp++; if (bus.dir !== exp_d[i]) begin n_err++; $display("FAIL sweep_dir[%0d] got %b want %b", i, bus.dir, exp_d[i]); end
            n_cmp++; if (bus.step !== 1'b1) begin n_err++; $display("FAIL sweep_step[%0d] got %b want 1", i, bus.step); end
            n_cmp++; if (bus.bounce !== exp_b[i]) begin n_err++; $display("FAIL sweep_bounce[%0d] got %b want %b", i, bus.bounce, exp_b[i]); end
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] exp_q [8] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04};
        logic       exp_s [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        do_reset();
        bus.en = 1'b1; bus.mode = 2'b00; bus.div = 4'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            $display("prescale %0d: Q=%h step=%b", i, bus.Q, bus.step);
            n_cmp++; if (bus.Q !== exp_q[i]) begin n_err++; $display("FAIL div3_q[%0d] got %h want %h", i, bus.Q, exp_q[i]); end
            n_cmp++; if (bus.step !== exp_s[i]) begin n_err++; $display("FAIL div3_step[%0d] got %b want %b", i, bus.step, exp_s[i]); end
        end
        // cnt now 0; two more edges bring it to 2 without a step.
        tick(); tick();
        n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL div3_cnt2_step got %b want 0", bus.step); end
        bus.div = 4'd0;
        tick();
        $display("div drop: Q=%h step=%b", bus.Q, bus.step);
        n_cmp++; if (bus.step !== 1'b1) begin n_err++; $display("FAIL divdrop_step got %b want 1", bus.step); end
        n_cmp++; if (bus.Q !== 8'h08) begin n_err++; $display("FAIL divdrop_q got %h want 08", bus.Q); end
    endtask

    task automatic test_load();
        do_reset();
        bus.en = 1'b1; bus.mode = 2'b00; bus.div = 4'd0;
        do_load(8'h81);
        $display("load 81: Q=%h dir=%b step=%b bounce=%b", bus.Q, bus.dir, bus.step, bus.bounce);
        n_cmp++; if (bus.Q !== 8'h81) begin n_err++; $display("FAIL load81_q got %h want 81", bus.Q); end
        n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL load81_step got %b want 0", bus.step); end
        n_cmp++; if (bus.bounce !== 1'b0) begin n_err++; $display("FAIL load81_bounce got %b want 0", bus.bounce); end
        n_cmp++; if (bus.dir !== 1'b0) begin n_err++; $display("FAIL load81_dir got %b want 0", bus.dir); end
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("both-ends %0d: Q=%h dir=%b step=%b bounce=%b", i, bus.Q, bus.dir, bus.step, bus.bounce);
            n_cmp++; if (bus.Q !== 8'h81) begin n_err++; $display("FAIL ends_q[%0d] got %h want 81", i, bus.Q); end
            n_cmp++; if (bus.dir !== ((i % 2) == 0)) begin n_err++; $display("FAIL ends_dir[%0d] got %b want %b", i, bus.dir, (i % 2) == 0); end
            n_cmp++; if (bus.bounce !== 1'b1) begin n_err++; $display("FAIL ends_bounce[%0d] got %b want 1", i, bus.bounce); end
            n_cmp++; if (bus.step !== 1'b1) begin n_err++; $display("FAIL ends_step[%0d] got %b want 1", i, bus.step); end
        end
        do_load(8'h00);
        n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL load00_step got %b want 0", bus.step); end
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("zero %0d: Q=%h dir=%b step=%b bounce=%b", i, bus.Q, bus.dir, bus.step, bus.bounce);
            n_cmp++; if (bus.Q !== 8'h00) begin n_err++; $display("FAIL zero_q[%0d] got %h want 00", i, bus.Q); end
            n_cmp++; if (bus.step !== 1'b1) begin n_err++; $display("FAIL zero_step[%0d] got %b want 1", i, bus.step); end
            n_cmp++; if (bus.bounce !== 1'b0) begin n_err++; $display("FAIL zero_bounce[%0d] got %b want 0", i, bus.bounce); end
            n_cmp++; if (bus.dir !== 1'b0) begin n_err++; $display("FAIL zero_dir[%0d] got %b want 0", i, bus.dir); end
        end
    endtask

    task automatic test_rotate();
        logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        logic [7:0] exp_q [4] = '{8'h01, 8'h80, 8'h40, 8'h80};
        logic       exp_d [4] = '{0, 1, 1, 0};
        do_reset();
        bus.div = 4'd0; bus.mode = 2'b00;
        do_load(8'h80);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mode = modes[i];
            tick();
            $display("rotate %0d mode=%b: Q=%h dir=%b bounce=%b", i, modes[i], bus.Q, bus.dir, bus.bounce);
            n_cmp++; if (bus.Q !== exp_q[i]) begin n_err++; $display("FAIL rot_q[%0d] got %h want %h", i, bus.Q, exp_q[i]); end
            n_cmp++; if (bus.dir !== exp_d[i]) begin n_err++; $display("FAIL rot_dir[%0d] got %b want %b", i, bus.dir, exp_d[i]); end
            n_cmp++; if (bus.bounce !== 1'b0) begin n_err++; $display("FAIL rot_bounce[%0d] got %b want 0", i, bus.bounce); end
            n_cmp++; if (bus.step !== 1'b1) begin n_err++; $display("FAIL rot_step[%0d] got %b want 1", i, bus.step); end
        end
    endtask

    // Freeze via en=0 (pass 0) and via mode=11 (pass 1); cnt sits at 2 of div=4.
    task automatic test_freeze();
        logic [7:0] start_q [2] = '{8'h08, 8'h10};
        logic [7:0] end_q   [2] = '{8'h10, 8'h20};
        do_reset();
        bus.mode = 2'b00; bus.div = 4'd4;
        do_load(8'h08);
        bus.en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            tick(); tick();
            if (p == 0) bus.en = 1'b0; else bus.mode = 2'b11;
            for (int i = 0; i < 5; i++) begin
                tick();
                $display("freeze p%0d %0d: Q=%h step=%b", p, i, bus.Q, bus.step);
                n_cmp++; if (bus.Q !== start_q[p]) begin n_err++; $display("FAIL frz_q[%0d][%0d] got %h want %h", p, i, bus.Q, start_q[p]); end
                n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL frz_step[%0d][%0d] got %b want 0", p, i, bus.step); end
            end
            bus.en = 1'b1; bus.mode = 2'b00;
            for (int i = 0; i < 3; i++) begin
                tick();
                $display("resume p%0d %0d: Q=%h step=%b", p, i, bus.Q, bus.step);
                n_cmp++; if (bus.step !== (i == 2)) begin n_err++; $display("FAIL res_step[%0d][%0d] got %b want %b", p, i, bus.step, i == 2); end
                n_cmp++; if (bus.Q !== ((i == 2) ? end_q[p] : start_q[p])) begin n_err++; $display("FAIL res_q[%0d][%0d] got %h", p, i, bus.Q); end
            end
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        bus.div = 4'd0; bus.mode = 2'b10;
        do_load(8'h40);
        bus.en = 1'b1;
        tick();
        n_cmp++; if (bus.Q !== 8'h20 || bus.dir !== 1'b1) begin n_err++; $display("FAIL pre_rst got Q=%h dir=%b want 20/1", bus.Q, bus.dir); end
        reset = 1'b1; bus.load = 1'b1; bus.load_val = 8'hFF;
        tick();
        reset = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
        $display("reset+load: Q=%h dir=%b step=%b bounce=%b", bus.Q, bus.dir, bus.step, bus.bounce);
        n_cmp++; if (bus.Q !== 8'h01) begin n_err++; $display("FAIL rstld_q got %h want 01", bus.Q); end
        n_cmp++; if (bus.dir !== 1'b0) begin n_err++; $display("FAIL rstld_dir got %b want 0", bus.dir); end
        n_cmp++; if (bus.step !== 1'b0) begin n_err++; $display("FAIL rstld_step got %b want 0", bus.step); end
        n_cmp++; if (bus.bounce !== 1'b0) begin n_err++; $display("FAIL rstld_bounce got %b want 0", bus.bounce); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.en = 1'b0; bus.mode = 2'b00; bus.div = 4'd0;
        bus.load = 1'b0; bus.load_val = 8'h00;
        test_reset();
        test_bounce_sweep();
        test_prescaler();
        test_load();
        test_rotate();
        test_freeze();
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
